// File: rtl/elevator_pkg.sv
// Shared constants, state type and call-mask helpers for the elevator call scheduler.
package elevator_pkg;

    localparam int unsigned NUM_LAMPS = 7;

    localparam logic [1:0] FLOOR_NONE = 2'b00;
    localparam logic [1:0] FLOOR_1    = 2'b01;
    localparam logic [1:0] FLOOR_2    = 2'b10;
    localparam logic [1:0] FLOOR_3    = 2'b11;

    localparam logic [1:0] DIR_NONE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    localparam int unsigned LAMP_U1 = 0;
    localparam int unsigned LAMP_U2 = 1;
    localparam int unsigned LAMP_D2 = 2;
    localparam int unsigned LAMP_D3 = 3;
    localparam int unsigned LAMP_F1 = 4;
    localparam int unsigned LAMP_F2 = 5;
    localparam int unsigned LAMP_F3 = 6;

    typedef enum logic [1:0] {IDLE, SELECT, ISSUE, SERVE} sched_state_t;

    // One bit per floor ({3,2,1}) set when any call is pending there.
    function automatic logic [2:0] floor_hits(input logic [NUM_LAMPS-1:0] lamps);
        floor_hits = {lamps[LAMP_D3] | lamps[LAMP_F3],
                      lamps[LAMP_U2] | lamps[LAMP_D2] | lamps[LAMP_F2],
                      lamps[LAMP_U1] | lamps[LAMP_F1]};
    endfunction

    // Every lamp bit belonging to floor k.
    function automatic logic [NUM_LAMPS-1:0] floor_mask(input logic [1:0] k);
        logic [NUM_LAMPS-1:0] m;
        m = '0;
        case (k)
            FLOOR_1: begin m[LAMP_U1] = 1'b1; m[LAMP_F1] = 1'b1; end
            FLOOR_2: begin m[LAMP_U2] = 1'b1; m[LAMP_D2] = 1'b1; m[LAMP_F2] = 1'b1; end
            FLOOR_3: begin m[LAMP_D3] = 1'b1; m[LAMP_F3] = 1'b1; end
            default: m = '0;
        endcase
        return m;
    endfunction

    // Calls served by a stop at floor k while sweeping in the given direction.
    function automatic logic [NUM_LAMPS-1:0] clear_mask(input logic [1:0] k,
                                                        input logic sweep_up,
                                                        input logic [NUM_LAMPS-1:0] lamps);
        logic [NUM_LAMPS-1:0] m;
        logic [2:0]           hits;
        logic                 beyond;
        m      = '0;
        hits   = floor_hits(lamps);
        beyond = sweep_up ? hits[2] : hits[0];
        case (k)
            FLOOR_1: begin m[LAMP_F1] = 1'b1; m[LAMP_U1] = 1'b1; end
            FLOOR_2: begin
                m[LAMP_F2] = 1'b1;
                if (sweep_up || !beyond) m[LAMP_U2] = 1'b1;
                if (!sweep_up || !beyond) m[LAMP_D2] = 1'b1;
            end
            FLOOR_3: begin m[LAMP_F3] = 1'b1; m[LAMP_D3] = 1'b1; end
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/elevator_btn_debounce.sv
// Single-button debouncer: pulses once after DEBOUNCE_CYCLES consecutive high samples,
// then stays disarmed until the button is released.
module elevator_btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press_c
);

    localparam int unsigned CNT_W = 4;

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES out of range 1..15");
    end

    logic [CNT_W-1:0] r_cnt;
    logic             r_armed;

    assign o_press_c = i_btn && r_armed && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    // Count consecutive high cycles; re-arm only once the button is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_armed <= 1'b1;
        end else if (!i_btn) begin
            r_cnt   <= '0;
            r_armed <= 1'b1;
        end else if (o_press_c) begin
            r_cnt   <= '0;
            r_armed <= 1'b0;
        end else if (r_armed) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/elevator_call_scheduler.sv
// Collective up/down call scheduler feeding targets to the elevator controller.
// Optional idle homing to floor 1 is enabled with the ELEV_HOMING_EN macro.
module elevator_call_scheduler
    import elevator_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES  = 2,
    parameter int unsigned IDLE_HOME_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       u1,
    input  logic       u2,
    input  logic       d2,
    input  logic       d3,
    input  logic       f1,
    input  logic       f2,
    input  logic       f3,
    input  logic [1:0] fs,
    input  logic       door,
    input  logic       tgt_ack,
    output logic [1:0] tgt_floor,
    output logic [1:0] tgt_dir,
    output logic       tgt_valid,
    output logic [6:0] lamps
);

    if (IDLE_HOME_CYCLES < 1 || IDLE_HOME_CYCLES > 255) begin : g_bad_home
        $error("IDLE_HOME_CYCLES out of range 1..255");
    end

    sched_state_t         r_state;
    logic [NUM_LAMPS-1:0] r_lamps;
    logic [1:0]           r_cur_floor;
    logic                 r_sweep_up;
    logic                 r_door_q;
    logic [1:0]           r_tgt_floor;
    logic [1:0]           r_tgt_dir;
    logic                 r_tgt_valid;

    logic [NUM_LAMPS-1:0] w_btn;
    logic [NUM_LAMPS-1:0] w_press;
    logic [NUM_LAMPS-1:0] w_clr;
    logic [NUM_LAMPS-1:0] w_lamps_nxt;
    logic [2:0]           w_hits;
    logic [1:0]           w_up_floor;
    logic [1:0]           w_dn_floor;
    logic [1:0]           w_sel_floor;
    logic [1:0]           w_sel_dir;
    logic                 w_sel_sweep_up;
    logic                 w_sel_local;
    logic                 w_arrive;
    logic                 w_homing_act;

    assign w_btn    = {f3, f2, f1, d3, d2, u2, u1};
    assign w_hits   = floor_hits(r_lamps);
    assign w_arrive = r_door_q && !door && (fs != FLOOR_NONE);

    for (genvar g = 0; g < NUM_LAMPS; g++) begin : g_btn
        elevator_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
            .clk       (clk),
            .rst       (rst),
            .i_btn     (w_btn[g]),
            .o_press_c (w_press[g])
        );
    end

`ifdef ELEV_HOMING_EN
    localparam int unsigned HOME_W = 8;
    logic [HOME_W-1:0] r_idle_cnt;
    logic              r_homing;
    assign w_homing_act = r_homing;
`else
    assign w_homing_act = 1'b0;
`endif

    // Nearest pending floor above and below the car, then sweep choice.
    always_comb begin
        w_up_floor     = FLOOR_NONE;
        w_dn_floor     = FLOOR_NONE;
        w_sel_floor    = r_cur_floor;
        w_sel_dir      = DIR_NONE;
        w_sel_sweep_up = r_sweep_up;
        w_sel_local    = 1'b0;
        case (r_cur_floor)
            FLOOR_1: begin
                if (w_hits[1])      w_up_floor = FLOOR_2;
                else if (w_hits[2]) w_up_floor = FLOOR_3;
            end
            FLOOR_2: begin
                if (w_hits[2]) w_up_floor = FLOOR_3;
                if (w_hits[0]) w_dn_floor = FLOOR_1;
            end
            FLOOR_3: begin
                if (w_hits[1])      w_dn_floor = FLOOR_2;
                else if (w_hits[0]) w_dn_floor = FLOOR_1;
            end
            default: ;
        endcase
        if (r_sweep_up && w_up_floor != FLOOR_NONE) begin
            w_sel_floor = w_up_floor;
            w_sel_dir   = DIR_UP;
        end else if (!r_sweep_up && w_dn_floor != FLOOR_NONE) begin
            w_sel_floor = w_dn_floor;
            w_sel_dir   = DIR_DOWN;
        end else if (r_sweep_up && w_dn_floor != FLOOR_NONE) begin
            w_sel_floor    = w_dn_floor;
            w_sel_dir      = DIR_DOWN;
            w_sel_sweep_up = 1'b0;
        end else if (!r_sweep_up && w_up_floor != FLOOR_NONE) begin
            w_sel_floor    = w_up_floor;
            w_sel_dir      = DIR_UP;
            w_sel_sweep_up = 1'b1;
        end else begin
            w_sel_local = 1'b1;
        end
    end

    // Lamp clearing for local-only calls at an open door and for arrivals; clear beats latch.
    always_comb begin
        w_clr = '0;
        if (r_state == SELECT && w_sel_local && !door)
            w_clr = floor_mask(r_cur_floor);
        else if (r_state == SERVE && w_arrive && !w_homing_act)
            w_clr = clear_mask(fs, r_sweep_up, r_lamps);
        w_lamps_nxt = (r_lamps | w_press) & ~w_clr;
    end

    // Scheduler FSM with registered target handshake and call lamps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_lamps     <= '0;
            r_cur_floor <= FLOOR_1;
            r_sweep_up  <= 1'b1;
            r_door_q    <= 1'b0;
            r_tgt_floor <= FLOOR_1;
            r_tgt_dir   <= DIR_NONE;
            r_tgt_valid <= 1'b0;
`ifdef ELEV_HOMING_EN
            r_idle_cnt  <= '0;
            r_homing    <= 1'b0;
`endif
        end else begin
            r_door_q <= door;
            r_lamps  <= w_lamps_nxt;
            if (fs != FLOOR_NONE) r_cur_floor <= fs;
`ifdef ELEV_HOMING_EN
            r_idle_cnt <= '0;
`endif
            case (r_state)
                IDLE: begin
                    if (r_lamps != '0) begin
                        r_state <= SELECT;
`ifdef ELEV_HOMING_EN
                    end else if (w_press != '0) begin
                        r_idle_cnt <= '0;
                    end else if (r_idle_cnt == HOME_W'(IDLE_HOME_CYCLES - 1)) begin
                        if (r_cur_floor != FLOOR_1) begin
                            r_homing    <= 1'b1;
                            r_tgt_floor <= FLOOR_1;
                            r_tgt_dir   <= DIR_DOWN;
                            r_tgt_valid <= 1'b1;
                            r_state     <= ISSUE;
                        end
                    end else begin
                        r_idle_cnt <= r_idle_cnt + HOME_W'(1);
`endif
                    end
                end
                SELECT: begin
                    if (w_sel_local && !door) begin
                        r_state <= IDLE;
                    end else begin
                        r_tgt_floor <= w_sel_floor;
                        r_tgt_dir   <= w_sel_dir;
                        r_sweep_up  <= w_sel_sweep_up;
                        r_tgt_valid <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (tgt_ack) begin
                        r_tgt_valid <= 1'b0;
                        r_state     <= SERVE;
                    end
                end
                SERVE: begin
                    if (w_arrive) begin
`ifdef ELEV_HOMING_EN
                        r_homing <= 1'b0;
`endif
                        r_state <= (w_lamps_nxt != '0) ? SELECT : IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tgt_floor = r_tgt_floor;
    assign tgt_dir   = r_tgt_dir;
    assign tgt_valid = r_tgt_valid;
    assign lamps     = r_lamps;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler (DEBOUNCE_CYCLES=2, IDLE_HOME_CYCLES=8).
module tb_elevator_call_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       u1, u2, d2, d3, f1, f2, f3;
    logic [1:0] fs;
    logic       door;
    logic       tgt_ack;
    logic [1:0] tgt_floor;
    logic [1:0] tgt_dir;
    logic       tgt_valid;
    logic [6:0] lamps;

    int n_cmp = 0;
    int n_err = 0;

    elevator_call_scheduler #(
        .DEBOUNCE_CYCLES  (2),
        .IDLE_HOME_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .u1        (u1),
        .u2        (u2),
        .d2        (d2),
        .d3        (d3),
        .f1        (f1),
        .f2        (f2),
        .f3        (f3),
        .fs        (fs),
        .door      (door),
        .tgt_ack   (tgt_ack),
        .tgt_floor (tgt_floor),
        .tgt_dir   (tgt_dir),
        .tgt_valid (tgt_valid),
        .lamps     (lamps)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (tgt_valid === 1'b1) break;
            step(1);
        end
        check(tag, 32'(tgt_valid), 32'd1);
    endtask

    task automatic ack_target();
        tgt_ack = 1'b1;
        step(1);
        tgt_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        {u1, u2, d2, d3, f1, f2, f3} = '0;
        fs = 2'b01;
        door = 1'b0;
        tgt_ack = 1'b0;
        step(2);
        check("rst_lamps", 32'(lamps), 32'h0);
        check("rst_valid", 32'(tgt_valid), 32'h0);
        check("rst_floor", 32'(tgt_floor), 32'h1);
        check("rst_dir",   32'(tgt_dir),   32'h0);
        rst = 1'b0;
        step(1);

        // One-cycle press is too short; two cycles latches u1.
        u1 = 1'b1; step(1); u1 = 1'b0;
        check("u1_short_a", 32'(lamps), 32'h0);
        step(1);
        check("u1_short_b", 32'(lamps), 32'h0);
        u1 = 1'b1; step(1);
        check("u1_one_cycle", 32'(lamps), 32'h0);
        step(1);
        check("u1_latch", 32'(lamps), 32'h01);
        // Only call is at the current floor with the door open: cleared, never issued.
        step(2);
        check("u1_local_clear", 32'(lamps), 32'h0);
        check("u1_no_issue", 32'(tgt_valid), 32'h0);
        step(3);
        check("u1_held_no_rearm", 32'(lamps), 32'h0);
        u1 = 1'b0; step(1);
        ack_target();
        check("ack_idle_ignored", 32'(tgt_valid), 32'h0);

        // f3 and d2 from floor 1: nearest upward call is floor 2.
        f3 = 1'b1; d2 = 1'b1; step(2); f3 = 1'b0; d2 = 1'b0;
        check("f3d2_lamps", 32'(lamps), 32'h44);
        wait_valid("wait_t2", 10);
        check("t2_floor", 32'(tgt_floor), 32'h2);
        check("t2_dir",   32'(tgt_dir),   32'h1);
        step(3);
        check("t2_hold_valid", 32'(tgt_valid), 32'h1);
        check("t2_hold_floor", 32'(tgt_floor), 32'h2);
        ack_target();
        check("t2_ack_drop", 32'(tgt_valid), 32'h0);
        door = 1'b1; fs = 2'b00; step(2);
        fs = 2'b10; step(1);
        door = 1'b0; step(1);
        // f3 still pending above floor 2, so d2 survives the up-sweep stop.
        check("arr2_f_lamps", 32'(lamps[6:4]), 32'h4);
        check("arr2_lamps", 32'(lamps), 32'h44);
        wait_valid("wait_t3", 10);
        check("t3_floor", 32'(tgt_floor), 32'h3);
        check("t3_dir",   32'(tgt_dir),   32'h1);

        // u2 pressed while stopped at 2 during ISSUE; next stop at 2 clears u2 only.
        u2 = 1'b1; step(2); u2 = 1'b0;
        check("u2_lamps", 32'(lamps), 32'h46);
        ack_target();
        door = 1'b1; step(1);
        door = 1'b0; step(1);
        check("arr2_u2_only", 32'(lamps), 32'h44);
        wait_valid("wait_t3b", 10);
        check("t3b_floor", 32'(tgt_floor), 32'h3);

        // New call during ISSUE must not disturb the frozen target.
        f2 = 1'b1; step(2); f2 = 1'b0;
        check("f2_lamps", 32'(lamps), 32'h64);
        check("frozen_floor", 32'(tgt_floor), 32'h3);
        check("frozen_valid", 32'(tgt_valid), 32'h1);
        ack_target();
        door = 1'b1; fs = 2'b00; step(2);
        fs = 2'b11; step(1);
        door = 1'b0; step(1);
        check("arr3_clear", 32'(lamps), 32'h24);
        // Nothing above floor 3: sweep reverses toward floor 2.
        wait_valid("wait_t2d", 10);
        check("t2d_floor", 32'(tgt_floor), 32'h2);
        check("t2d_dir",   32'(tgt_dir),   32'h2);

        // Asynchronous reset in SERVE drops everything immediately.
        ack_target();
        u1 = 1'b1; step(2); u1 = 1'b0;
        check("serve_lamps", 32'(lamps), 32'h25);
        #2 rst = 1'b1;
        #1;
        check("arst_lamps", 32'(lamps), 32'h0);
        check("arst_valid", 32'(tgt_valid), 32'h0);
        check("arst_floor", 32'(tgt_floor), 32'h1);
        check("arst_dir",   32'(tgt_dir),   32'h0);
        step(2);
        rst = 1'b0;
        fs = 2'b11; door = 1'b0;
        step(1);

        // Idle at floor 3.
`ifdef ELEV_HOMING_EN
        wait_valid("home_wait", 20);
        check("home_floor", 32'(tgt_floor), 32'h1);
        check("home_dir",   32'(tgt_dir),   32'h2);
        check("home_lamps", 32'(lamps),     32'h0);
`else
        step(20);
        check("no_home_valid", 32'(tgt_valid), 32'h0);
        check("no_home_lamps", 32'(lamps),     32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
